// File: rtl/rvfi_commit_tracker.sv
// Purpose: assigns consecutive order numbers to up to NUM_CH retiring packets per cycle and queues them for the monitor.
// Latency: a packet accepted on cycle N is presented at the head on cycle N+1 at the earliest; no bypass path.
// Backpressure: in_ready drops when fewer than NUM_CH slots are free; offered groups are then dropped and overflow_err latches.
// Optional: define RVFI_COMMIT_WATCHDOG_EN to build the idle-commit watchdog behind wdog_err.
module rvfi_commit_tracker #(
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 8,
    parameter int PKT_W      = 256,
    parameter int ORDER_W    = 64,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*PKT_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ORDER_W-1:0]      out_order,
    output logic [PKT_W-1:0]        out_data,
    output logic [ORDER_W-1:0]      commit_count,
    output logic                    overflow_err,
    output logic                    wdog_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Highest occupancy that still leaves room for a full commit group.
    localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(DEPTH - NUM_CH);

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   occ;
    logic [ORDER_W-1:0] order_cnt;
    logic [PKT_W-1:0]   mem_data  [DEPTH];
    logic [ORDER_W-1:0] mem_order [DEPTH];

    logic [CNT_W-1:0]   lane_off [NUM_CH];
    logic [CNT_W-1:0]   grp_cnt;
    logic               accept;
    logic               deq;

    // Compaction offsets: each valid lane lands after all lower-numbered valid lanes.
    always_comb begin
        grp_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane_off[i] = grp_cnt;
            grp_cnt     = grp_cnt + CNT_W'(in_valid[i]);
        end
    end

    // in_ready looks only at registered occupancy, so a same-cycle pop never opens room.
    assign in_ready     = (occ <= ROOM_MAX);
    assign accept       = in_ready && (|in_valid);
    assign out_valid    = (occ != '0);
    assign deq          = out_valid && out_ready;
    assign out_data     = mem_data[head];
    assign out_order    = mem_order[head];
    assign commit_count = order_cnt;

    // Pointers, occupancy, order counter and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            occ          <= '0;
            order_cnt    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (accept) begin
                tail      <= tail + PTR_W'(grp_cnt);
                order_cnt <= order_cnt + ORDER_W'(grp_cnt);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            occ <= occ + (accept ? grp_cnt : CNT_W'(0)) - CNT_W'(deq);
            if ((|in_valid) && !in_ready) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Entry storage: valid lanes are written into consecutive tail slots with their order numbers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_data[j]  <= '0;
                mem_order[j] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_valid[i]) begin
                    mem_data[tail + PTR_W'(lane_off[i])]  <= in_data[i*PKT_W +: PKT_W];
                    mem_order[tail + PTR_W'(lane_off[i])] <= order_cnt + ORDER_W'(lane_off[i]);
                end
            end
        end
    end

`ifdef RVFI_COMMIT_WATCHDOG_EN
    localparam int IDLE_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(WDOG_LIMIT);

    logic [IDLE_W-1:0] idle_cnt;
    logic              wdog_q;

    // Idle counter saturates at the limit; the error latches as the count reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            wdog_q   <= 1'b0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
            if (idle_cnt == IDLE_MAX - IDLE_W'(1)) begin
                wdog_q <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_q;
`else
    logic [31:0] wdog_limit_unused;
    assign wdog_limit_unused = 32'(WDOG_LIMIT);
    assign wdog_err          = 1'b0;
`endif

endmodule
